// File: rtl/cpu_bus_pkg.sv
// rtl/cpu_bus_pkg.sv - shared bus size encodings, FSM states and alignment helper
package cpu_bus_pkg;

  localparam logic [2:0] BHW_BYTE = 3'b001;
  localparam logic [2:0] BHW_HALF = 3'b010;
  localparam logic [2:0] BHW_WORD = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } bus_state_e;

  function automatic logic is_misaligned(input logic [2:0] bhw, input logic [1:0] lsb);
    case (bhw)
      BHW_BYTE: return 1'b0;
      BHW_HALF: return lsb[0];
      BHW_WORD: return lsb != 2'b00;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin one-hot grant, priority starts after the last grant
module rr_arbiter #(
  parameter int NUM_CH = 2
) (
  input  logic [NUM_CH-1:0] i_req,
  input  logic [NUM_CH-1:0] i_last_grant,
  output logic [NUM_CH-1:0] o_grant
);

  int                start_idx;
  logic [NUM_CH-1:0] mask;
  logic [NUM_CH-1:0] masked;
  logic [NUM_CH-1:0] pick;

  always_comb begin
    start_idx = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (i_last_grant[i]) start_idx = i + 1;
    end
    mask = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      mask[i] = (i >= start_idx);
    end
    // Nothing at or above the start point: wrap around to the lowest requester.
    masked = i_req & mask;
    pick   = (|masked) ? masked : i_req;
    o_grant = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (pick[i]) begin
        o_grant    = '0;
        o_grant[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cpu_bus_arbiter.sv
// rtl/cpu_bus_arbiter.sv - multi-channel CPU bus arbiter, one transaction at a time
// Optional WAIT timeout is built in when BUS_TIMEOUT_EN is defined.
module cpu_bus_arbiter
  import cpu_bus_pkg::*;
#(
  parameter int NUM_CH         = 2,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NUM_CH-1:0]        i_req,
  input  logic [NUM_CH*ADDR_W-1:0] i_req_addr,
  input  logic [NUM_CH*DATA_W-1:0] i_req_wdata,
  input  logic [NUM_CH*3-1:0]      i_req_bhw,
  input  logic [NUM_CH-1:0]        i_req_write,
  output logic [NUM_CH-1:0]        o_req_ack,
  output logic [NUM_CH-1:0]        o_rsp_DV,
  output logic [DATA_W-1:0]        o_rsp_data,
  output logic                     o_rsp_err,
  output logic [ADDR_W-1:0]        o_bus_address,
  output logic [DATA_W-1:0]        o_bus_data,
  output logic                     o_bus_DV,
  output logic [2:0]               o_bhw,
  output logic                     o_write_notread,
  input  logic [DATA_W-1:0]        i_bus_data,
  input  logic                     i_bus_DV,
  output logic                     o_busy
);

  bus_state_e        state_q, state_d;
  logic [NUM_CH-1:0] grant;
  logic [NUM_CH-1:0] last_q;
  logic [NUM_CH-1:0] gnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [2:0]        bhw_q;
  logic              write_q;
  logic              misalign_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [2:0]        sel_bhw;
  logic              sel_write;
  logic              sel_misalign;
  logic              timeout;

  rr_arbiter #(.NUM_CH(NUM_CH)) u_rr (
    .i_req        (i_req),
    .i_last_grant (last_q),
    .o_grant      (grant)
  );

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_bhw   = '0;
    sel_write = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (grant[c]) begin
        sel_addr  = i_req_addr[c*ADDR_W +: ADDR_W];
        sel_wdata = i_req_wdata[c*DATA_W +: DATA_W];
        sel_bhw   = i_req_bhw[c*3 +: 3];
        sel_write = i_req_write[c];
      end
    end
    sel_misalign = is_misaligned(sel_bhw, sel_addr[1:0]);
  end

`ifdef BUS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt_q;

  always_ff @(posedge i_clk) begin
    if (i_rst || state_q != ST_WAIT) wait_cnt_q <= '0;
    else                             wait_cnt_q <= wait_cnt_q + CNT_W'(1);
  end

  assign timeout = (state_q == ST_WAIT) && (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  // Timeout length only matters when the counter is built in.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (|i_req) state_d = ST_ISSUE;
      ST_ISSUE: state_d = misalign_q ? ST_RESP : ST_WAIT;
      ST_WAIT:  if (i_bus_DV || timeout) state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      last_q     <= '0;
      gnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      bhw_q      <= '0;
      write_q    <= 1'b0;
      misalign_q <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (|i_req) begin
            last_q     <= grant;
            gnt_q      <= grant;
            addr_q     <= sel_addr;
            wdata_q    <= sel_wdata;
            bhw_q      <= sel_bhw;
            write_q    <= sel_write;
            misalign_q <= sel_misalign;
            rdata_q    <= '0;
            err_q      <= sel_misalign;
          end
        end
        ST_WAIT: begin
          // Store acknowledgements carry bus data too; it is returned unchanged.
          if (i_bus_DV) begin
            rdata_q <= i_bus_data;
            err_q   <= 1'b0;
          end else if (timeout) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_req_ack       = (state_q == ST_IDLE && !i_rst) ? grant : '0;
  assign o_bus_DV        = (state_q == ST_ISSUE) && !misalign_q;
  assign o_bus_address   = addr_q;
  assign o_bus_data      = wdata_q;
  assign o_bhw           = bhw_q;
  assign o_write_notread = write_q;
  assign o_rsp_DV        = (state_q == ST_RESP) ? gnt_q : '0;
  assign o_rsp_data      = (state_q == ST_RESP) ? rdata_q : '0;
  assign o_rsp_err       = (state_q == ST_RESP) && err_q;
  assign o_busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// tb/tb_cpu_bus_arbiter.sv - directed and randomized checks of cpu_bus_arbiter against a transaction model
module tb_cpu_bus_arbiter;
  import cpu_bus_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req_v;
  logic [31:0] ch_addr [3];
  logic [31:0] ch_wdata[3];
  logic [2:0]  ch_bhw  [3];
  logic        ch_write[3];
  logic [31:0] bus_data;
  logic        bus_dv;

  logic [2:0]  o_req_ack, o_rsp_DV, o_bhw;
  logic [31:0] o_rsp_data, o_bus_address, o_bus_data;
  logic        o_rsp_err, o_bus_DV, o_write_notread, o_busy;

  int n_pass  = 0;
  int n_total = 0;
  int last_g  = 2;
  logic [1:0] g;

  always #5 clk = ~clk;

  cpu_bus_arbiter #(.NUM_CH(3), .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(4)) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_req           (req_v),
    .i_req_addr      ({ch_addr[2], ch_addr[1], ch_addr[0]}),
    .i_req_wdata     ({ch_wdata[2], ch_wdata[1], ch_wdata[0]}),
    .i_req_bhw       ({ch_bhw[2], ch_bhw[1], ch_bhw[0]}),
    .i_req_write     ({ch_write[2], ch_write[1], ch_write[0]}),
    .o_req_ack       (o_req_ack),
    .o_rsp_DV        (o_rsp_DV),
    .o_rsp_data      (o_rsp_data),
    .o_rsp_err       (o_rsp_err),
    .o_bus_address   (o_bus_address),
    .o_bus_data      (o_bus_data),
    .o_bus_DV        (o_bus_DV),
    .o_bhw           (o_bhw),
    .o_write_notread (o_write_notread),
    .i_bus_data      (bus_data),
    .i_bus_DV        (bus_dv),
    .o_busy          (o_busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic bit misal(input logic [2:0] bhw, input logic [31:0] a);
    if (bhw == BHW_HALF) return (a % 2) != 0;
    if (bhw == BHW_WORD) return (a % 4) != 0;
    return 1'b0;
  endfunction

  // Next channel in circular order after the last granted one.
  function automatic logic [1:0] rr_pick(input logic [2:0] r, input int last);
    rr_pick = 2'd0;
    for (int i = 3; i >= 1; i--) begin
      if (r[2'((last + i) % 3)]) rr_pick = 2'((last + i) % 3);
    end
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic raise(input logic [1:0] c, input logic [31:0] a, input logic [2:0] b,
                       input logic w, input logic [31:0] d);
    ch_addr[c]  = a;
    ch_bhw[c]   = b;
    ch_write[c] = w;
    ch_wdata[c] = d;
    req_v[c]    = 1'b1;
  endtask

  task automatic raise_rand(input logic [1:0] c);
    raise(c, $urandom, 3'(1 << $urandom_range(0, 2)), 1'($urandom_range(0, 1)), $urandom);
  endtask

  // Runs one transaction from the IDLE cycle in which the acknowledge is expected.
  task automatic txn(input int k, input logic [31:0] bdata, input bit stray, output logic [1:0] g_obs);
    logic [1:0] gx;
    logic [2:0] oh;
    bit         mis;
    gx  = rr_pick(req_v, last_g);
    oh  = 3'(1 << gx);
    mis = misal(ch_bhw[gx], ch_addr[gx]);
    @(negedge clk);
    chk("ack", 64'(o_req_ack), 64'(oh));
    chk("busy_idle", 64'(o_busy), 64'(0));
    g_obs = 2'd3;
    for (int c = 0; c < 3; c++) if (o_req_ack[2'(c)]) g_obs = 2'(c);
    cyc();
    req_v[gx] = 1'b0;
    if (stray) begin
      bus_dv   = 1'b1;
      bus_data = $urandom;
    end
    @(negedge clk);
    chk("bus_dv_issue", 64'(o_bus_DV), 64'(!mis));
    chk("ack_issue", 64'(o_req_ack), 64'(0));
    chk("busy_issue", 64'(o_busy), 64'(1));
    if (!mis) begin
      chk("bus_addr", 64'(o_bus_address), 64'(ch_addr[gx]));
      chk("bus_data", 64'(o_bus_data), 64'(ch_wdata[gx]));
      chk("bus_bhw", 64'(o_bhw), 64'(ch_bhw[gx]));
      chk("bus_write", 64'(o_write_notread), 64'(ch_write[gx]));
    end
    cyc();
    bus_dv = 1'b0;
    if (!mis) begin
      for (int j = 1; j <= k; j++) begin
        if (j == k) begin
          bus_dv   = 1'b1;
          bus_data = bdata;
        end
        @(negedge clk);
        chk("wait_no_rsp", 64'(o_rsp_DV), 64'(0));
        chk("wait_no_bus_dv", 64'(o_bus_DV), 64'(0));
        chk("wait_no_ack", 64'(o_req_ack), 64'(0));
        chk("addr_hold", 64'(o_bus_address), 64'(ch_addr[gx]));
        chk("bhw_hold", 64'(o_bhw), 64'(ch_bhw[gx]));
        cyc();
        bus_dv = 1'b0;
      end
    end
    @(negedge clk);
    chk("rsp_dv", 64'(o_rsp_DV), 64'(oh));
    chk("rsp_err", 64'(o_rsp_err), 64'(mis));
    chk("rsp_data", 64'(o_rsp_data), mis ? 64'(0) : 64'(bdata));
    chk("resp_no_ack", 64'(o_req_ack), 64'(0));
    cyc();
    last_g = int'(gx);
  endtask

  initial begin
    rst      = 1'b1;
    req_v    = '0;
    bus_dv   = 1'b0;
    bus_data = '0;
    for (int c = 0; c < 3; c++) begin
      ch_addr[c] = '0; ch_wdata[c] = '0; ch_bhw[c] = BHW_WORD; ch_write[c] = 1'b0;
    end
    cyc(); cyc();
    @(negedge clk);
    chk("rst_busy", 64'(o_busy), 64'(0));
    chk("rst_rsp_dv", 64'(o_rsp_DV), 64'(0));
    chk("rst_bus_dv", 64'(o_bus_DV), 64'(0));
    chk("rst_addr", 64'(o_bus_address), 64'(0));
    cyc();
    rst = 1'b0;

    // ch1 word load, bus answers two cycles after the bus strobe
    raise(2'd1, 32'h100, BHW_WORD, 1'b0, 32'h0);
    txn(2, 32'hDEADBEEF, 1'b0, g);
    chk("load_grant", 64'(g), 64'(1));

    // stray bus strobe while idle
    bus_dv = 1'b1; bus_data = 32'h12345678;
    @(negedge clk);
    chk("idle_stray_rsp", 64'(o_rsp_DV), 64'(0));
    chk("idle_stray_busy", 64'(o_busy), 64'(0));
    cyc();
    bus_dv = 1'b0;
    @(negedge clk);
    chk("idle_stray_rsp2", 64'(o_rsp_DV), 64'(0));
    cyc();

    // ch0 and ch1 requesting back to back alternate
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        if (!req_v[0]) raise(2'd0, 32'h1000 + 32'(i * 4), BHW_WORD, 1'b0, $urandom);
        if (!req_v[1]) raise(2'd1, 32'h2000 + 32'(i * 4), BHW_WORD, 1'b1, $urandom);
      end
      txn(1, $urandom, 1'b1, g);
      chk("alternate", 64'(g), 64'(i % 2));
    end

    // misaligned half store skips the bus
    raise(2'd1, 32'h103, BHW_HALF, 1'b1, 32'h0000BEEF);
    txn(1, 32'h0, 1'b0, g);
    chk("misalign_grant", 64'(g), 64'(1));

    // WAIT with no bus answer
    raise(2'd2, 32'h40, BHW_WORD, 1'b0, 32'h0);
    @(negedge clk);
    chk("to_ack", 64'(o_req_ack), 64'(3'b100));
    cyc();
    req_v[2] = 1'b0;
    @(negedge clk);
    chk("to_bus_dv", 64'(o_bus_DV), 64'(1));
    cyc();
`ifdef BUS_TIMEOUT_EN
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk("to_wait_no_rsp", 64'(o_rsp_DV), 64'(0));
      cyc();
    end
    @(negedge clk);
    chk("to_rsp_dv", 64'(o_rsp_DV), 64'(3'b100));
    chk("to_rsp_err", 64'(o_rsp_err), 64'(1));
    chk("to_rsp_data", 64'(o_rsp_data), 64'(0));
    cyc();
    last_g = 2;
`else
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      chk("wait_forever_busy", 64'(o_busy), 64'(1));
      chk("wait_forever_rsp", 64'(o_rsp_DV), 64'(0));
      cyc();
    end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    last_g = 2;
`endif

    // reset in WAIT discards the transaction and the late bus answer
    raise(2'd0, 32'h200, BHW_WORD, 1'b0, 32'h0);
    @(negedge clk);
    chk("rw_ack", 64'(o_req_ack), 64'(3'b001));
    cyc();
    req_v[0] = 1'b0;
    cyc();
    @(negedge clk);
    chk("rw_busy_wait", 64'(o_busy), 64'(1));
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0; bus_dv = 1'b1; bus_data = 32'hCAFEF00D;
    @(negedge clk);
    chk("rw_busy", 64'(o_busy), 64'(0));
    chk("rw_rsp", 64'(o_rsp_DV), 64'(0));
    chk("rw_addr", 64'(o_bus_address), 64'(0));
    cyc();
    bus_dv = 1'b0;
    @(negedge clk);
    chk("rw_rsp2", 64'(o_rsp_DV), 64'(0));
    cyc();
    last_g = 2;
    raise(2'd0, 32'h300, BHW_BYTE, 1'b0, 32'h0);
    raise(2'd1, 32'h304, BHW_WORD, 1'b0, 32'h0);
    txn(1, 32'h0000_00A5, 1'b0, g);
    chk("post_rst_grant", 64'(g), 64'(0));

    // randomized traffic against the model
    for (int n = 0; n < 40; n++) begin
      for (int c = 0; c < 3; c++) begin
        if (!req_v[2'(c)] && $urandom_range(0, 1) == 1) raise_rand(2'(c));
      end
      if (req_v == 3'b000) raise_rand(2'($urandom_range(0, 2)));
      txn(int'($urandom_range(1, 4)), $urandom, 1'($urandom_range(0, 1)), g);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
